// File: rtl/pwm_duty_scheduler_if.sv
// Duty-update request bus between the duty requesters (master) and pwm_duty_scheduler (slave).
interface pwm_duty_scheduler_if #(
  parameter int WIDTH_TRIANG = 6,
  parameter int N_CH         = 2
);
  logic [N_CH-1:0]                  req_valid;
  logic [N_CH*(WIDTH_TRIANG+1)-1:0] req_duty;
  logic [N_CH-1:0]                  req_ready;
  logic [N_CH-1:0]                  pending;

  modport master (output req_valid, output req_duty, input req_ready, input pending);
  modport slave  (input req_valid, input req_duty, output req_ready, output pending);
endinterface

// File: rtl/pwm_duty_scheduler.sv
// Round-robin duty scheduler feeding tear-free compare registers for a shared triangular carrier.
// Define PWM_DOUBLE_UPDATE_EN to also commit shadows at the carrier peak.
module pwm_duty_scheduler #(
  parameter int WIDTH_TRIANG = 6,
  parameter int N_CH         = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH_TRIANG-1:0] carrier,
  pwm_duty_scheduler_if.slave     req_bus,
  output logic                    commit,
  output logic [N_CH-1:0]         pwm_out
);
  localparam int DW = WIDTH_TRIANG + 1;
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [DW-1:0] FULL = {1'b1, {WIDTH_TRIANG{1'b0}}};

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   ptr_next;
  logic [N_CH-1:0] grant;
  logic            found;
  logic            commit_pt;
  logic [N_CH-1:0] pending;
  logic [DW-1:0]   shadow   [N_CH];
  logic [DW-1:0]   active   [N_CH];
  logic [DW-1:0]   duty_sat [N_CH];

  // First asserted request at or after the round-robin pointer wins.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!found && req_bus.req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

  assign ptr_next = (grant_idx == PW'(N_CH - 1)) ? '0 : grant_idx + PW'(1);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      duty_sat[i] = req_bus.req_duty[i*DW +: DW];
      if (duty_sat[i] > FULL) duty_sat[i] = FULL;
    end
  end

`ifdef PWM_DOUBLE_UPDATE_EN
  assign commit_pt = (carrier == '0) || (carrier == '1);
`else
  assign commit_pt = (carrier == '0);
`endif

  assign req_bus.req_ready = rst ? '0 : grant;
  assign req_bus.pending   = pending;

  // Commit reads the pre-edge shadow, so a same-cycle transfer stays pending for the next turning point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      commit  <= 1'b0;
      pending <= '0;
      pwm_out <= '0;
      for (int i = 0; i < N_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      commit <= commit_pt;
      if (found) ptr <= ptr_next;
      for (int i = 0; i < N_CH; i++) begin
        pwm_out[i] <= ({1'b0, carrier} < active[i]);
        if (commit_pt && pending[i]) active[i] <= shadow[i];
        if (grant[i]) begin
          shadow[i]  <= duty_sat[i];
          pending[i] <= 1'b1;
        end else if (commit_pt) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Self-checking bench for pwm_duty_scheduler: directed steps plus a per-cycle scoreboard of pwm_out/pending/commit.
module tb_pwm_duty_scheduler;
  localparam int W  = 6;
  localparam int N  = 2;
  localparam int DW = W + 1;
  localparam int PERIOD = 2 * (1 << W) - 2;

  typedef struct packed {
    logic [N-1:0] pwm;
    logic [N-1:0] pend;
    logic         cmt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] carrier;
  logic         commit;
  logic [N-1:0] pwm_out;

  int   checks = 0;
  int   errors = 0;
  int   tri_cnt;
  exp_t sb_q[$];

  int           m_shadow [N];
  int           m_active [N];
  logic [N-1:0] m_pending;
  int           m_ptr;

  pwm_duty_scheduler_if #(.WIDTH_TRIANG(W), .N_CH(N)) bus ();

  pwm_duty_scheduler #(.WIDTH_TRIANG(W), .N_CH(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .carrier (carrier),
    .req_bus (bus),
    .commit  (commit),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input int d0, input int d1);
    bus.req_valid = valid;
    bus.req_duty  = {7'(d1), 7'(d0)};
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_pending = '0;
    m_ptr     = 0;
  endtask

  function automatic int sat(input int d);
    return (d > (1 << W)) ? (1 << W) : d;
  endfunction

  // One carrier step: predict the edge from the spec-level model, then compare after it.
  task automatic tick();
    logic [N-1:0] exp_grant;
    logic         cpt;
    int           g;
    int           idx;
    exp_t         e;
    #1;
    g = -1;
    exp_grant = '0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && bus.req_valid[idx]) g = idx;
    end
    if (g >= 0) exp_grant[g] = 1'b1;
    checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_grant));
    for (int i = 0; i < N; i++) e.pwm[i] = (int'(carrier) < m_active[i]);
`ifdef PWM_DOUBLE_UPDATE_EN
    cpt = (int'(carrier) == 0) || (int'(carrier) == (1 << W) - 1);
`else
    cpt = (int'(carrier) == 0);
`endif
    if (cpt) begin
      for (int i = 0; i < N; i++) begin
        if (m_pending[i]) begin
          m_active[i]  = m_shadow[i];
          m_pending[i] = 1'b0;
        end
      end
    end
    if (g >= 0) begin
      m_shadow[g]  = sat(int'(bus.req_duty[g*DW +: DW]));
      m_pending[g] = 1'b1;
      m_ptr        = (g + 1) % N;
    end
    e.pend = m_pending;
    e.cmt  = cpt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checkOutput("pwm_out", 32'(pwm_out), 32'(e.pwm));
    checkOutput("pending", 32'(bus.pending), 32'(e.pend));
    checkOutput("commit", 32'(commit), 32'(e.cmt));
    tri_cnt = (tri_cnt + 1) % PERIOD;
    carrier = W'((tri_cnt <= (1 << W) - 1) ? tri_cnt : PERIOD - tri_cnt);
  endtask

  task automatic run_until(input int target, input logic rising);
    int n;
    n = 0;
    while (!(int'(carrier) == target && (tri_cnt <= (1 << W) - 1) == rising) && n < 300) begin
      tick();
      n++;
    end
    checkOutput("run_until_bound", 32'(n < 300), 32'(1));
  endtask

  task automatic wait_commit(output int at_carrier);
    int n;
    int c;
    n = 0;
    at_carrier = -1;
    while (n < 300) begin
      c = int'(carrier);
      tick();
      n++;
      if (commit === 1'b1) begin
        at_carrier = c;
        break;
      end
    end
    checkOutput("commit_bound", 32'(n < 300), 32'(1));
  endtask

  task automatic count_period(output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      if (pwm_out[0] === 1'b1) c0++;
      if (pwm_out[1] === 1'b1) c1++;
    end
  endtask

  initial begin
    int at_c;
    int c0;
    int c1;
    logic [N-1:0] arb_exp [4];
    arb_exp = '{2'b10, 2'b01, 2'b10, 2'b01};

    rst     = 1'b1;
    carrier = '0;
    tri_cnt = 0;
    applyStimulus(2'b11, 0, 0);
    model_reset();
    #2;
    checkOutput("reset_pending", 32'(bus.pending), 32'(0));
    checkOutput("reset_pwm", 32'(pwm_out), 32'(0));
    checkOutput("reset_commit", 32'(commit), 32'(0));
    checkOutput("reset_ready", 32'(bus.req_ready), 32'(0));
    @(posedge clk);
    @(posedge clk);
    applyStimulus(2'b00, 0, 0);
    #1;
    rst = 1'b0;

    $display("[TB] single update on ch0");
    run_until(10, 1'b1);
    applyStimulus(2'b01, 32, 0);
    tick();
    applyStimulus(2'b00, 0, 0);
    checkOutput("single_pending", 32'(bus.pending), 32'(2'b01));
    checkOutput("single_pwm_unchanged", 32'(pwm_out[0]), 32'(0));
    wait_commit(at_c);
`ifdef PWM_DOUBLE_UPDATE_EN
    checkOutput("single_commit_at", 32'(at_c), 32'(63));
`else
    checkOutput("single_commit_at", 32'(at_c), 32'(0));
`endif
    checkOutput("single_pending_clr", 32'(bus.pending), 32'(0));
    run_until(0, 1'b1);
    tick();
    count_period(c0, c1);
    checkOutput("duty32_high", 32'(c0), 32'(63));

    $display("[TB] arbitration with both requesters");
    run_until(20, 1'b1);
    applyStimulus(2'b11, 20, 50);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("arb_alt", 32'(bus.req_ready), 32'(arb_exp[i]));
      tick();
    end
    checkOutput("arb_pending_both", 32'(bus.pending), 32'(2'b11));

    $display("[TB] reset mid-run");
    rst = 1'b1;
    #1;
    checkOutput("midrst_pending", 32'(bus.pending), 32'(0));
    checkOutput("midrst_pwm", 32'(pwm_out), 32'(0));
    checkOutput("midrst_commit", 32'(commit), 32'(0));
    checkOutput("midrst_ready", 32'(bus.req_ready), 32'(0));
    model_reset();
    #1;
    rst = 1'b0;
    #1;
    checkOutput("ptr_after_reset", 32'(bus.req_ready), 32'(2'b01));
    applyStimulus(2'b00, 0, 0);

    $display("[TB] transfer and commit collide on ch1");
    run_until(20, 1'b0);
    applyStimulus(2'b10, 0, 40);
    tick();
    applyStimulus(2'b00, 0, 0);
    run_until(0, 1'b1);
    applyStimulus(2'b10, 0, 10);
    tick();
    applyStimulus(2'b00, 0, 0);
    checkOutput("collide_pending", 32'(bus.pending), 32'(2'b10));
    count_period(c0, c1);
`ifdef PWM_DOUBLE_UPDATE_EN
    checkOutput("collide_first_high", 32'(c1), 32'(49));
`else
    checkOutput("collide_first_high", 32'(c1), 32'(79));
`endif
    count_period(c0, c1);
    checkOutput("collide_second_high", 32'(c1), 32'(19));

    $display("[TB] duty extremes");
    run_until(20, 1'b0);
    applyStimulus(2'b11, 0, 64);
    tick();
    tick();
    applyStimulus(2'b00, 0, 0);
    run_until(0, 1'b1);
    tick();
    count_period(c0, c1);
    checkOutput("duty0_high", 32'(c0), 32'(0));
    checkOutput("duty64_high", 32'(c1), 32'(PERIOD));
    run_until(20, 1'b0);
    applyStimulus(2'b11, 100, 0);
    tick();
    tick();
    applyStimulus(2'b00, 0, 0);
    run_until(0, 1'b1);
    tick();
    count_period(c0, c1);
    checkOutput("duty100_sat_high", 32'(c0), 32'(PERIOD));
    checkOutput("duty0_ch1_high", 32'(c1), 32'(0));

    $display("[TB] commit point after a write on the rising slope");
    run_until(40, 1'b1);
    applyStimulus(2'b01, 20, 0);
    tick();
    applyStimulus(2'b00, 0, 0);
    wait_commit(at_c);
`ifdef PWM_DOUBLE_UPDATE_EN
    checkOutput("opt_commit_at", 32'(at_c), 32'(63));
`else
    checkOutput("opt_commit_at", 32'(at_c), 32'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
